// File: rtl/gpo_seq.sv
`default_nettype none
// ============================================================================
// Module   : gpo_seq
// Function : MMIO-slot GPO pattern sequencer; plays up to eight W-bit patterns
//            on dout with a programmable hold time, once or looped (W <= 32).
// Revision : 1.0 - initial release
// ============================================================================
module gpo_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic [W-1:0] dout
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [31:0] r_cnt;
  logic        r_done;
  logic [31:0] r_period;
  logic [2:0]  r_last;
  logic        r_loop;
  logic [W-1:0] r_idle;
  logic [W-1:0] r_pat [8];

  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_stop;
  logic [31:0] w_per_m1;
  logic        w_step;
  logic        w_seq_end;
  logic        w_busy;
  logic        w_unused;

  assign w_wr      = cs && write;
  assign w_ctrl_wr = w_wr && (addr == 5'd0);
  assign w_stop    = w_ctrl_wr && wr_data[1];
  assign w_start   = w_ctrl_wr && wr_data[0] && !wr_data[1];
  assign w_per_m1  = (r_period == 32'd0) ? 32'd0 : r_period - 32'd1;
  assign w_step    = (r_cnt == w_per_m1);
  // Index 7 always terminates a pass, so a LAST lowered below idx still ends.
  assign w_seq_end = (r_idx == r_last) || (r_idx == 3'd7);
  assign w_busy    = (r_state == S_RUN);
  assign w_unused  = read;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period <= '0;
      r_last   <= '0;
      r_loop   <= 1'b0;
      r_idle   <= '0;
      for (int i = 0; i < 8; i++) r_pat[i] <= '0;
    end else if (w_wr) begin
      case (addr)
        5'd0: r_loop   <= wr_data[2];
        5'd1: r_period <= wr_data;
        5'd2: r_last   <= wr_data[2:0];
        5'd3: r_idle   <= wr_data[W-1:0];
        default: begin
          if (addr[4:3] == 2'b01) r_pat[addr[2:0]] <= wr_data[W-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (w_stop) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_state <= S_RUN;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_step) begin
        r_cnt <= '0;
        if (!w_seq_end) begin
          r_idx <= r_idx + 3'd1;
        end else if (r_loop) begin
          r_idx <= '0;
        end else begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign dout = w_busy ? r_pat[r_idx] : r_idle;

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0: rd_data = {25'd0, r_idx, 1'b0, r_loop, r_done, w_busy};
      5'd1: rd_data = r_period;
      5'd2: rd_data = {29'd0, r_last};
      5'd3: rd_data[W-1:0] = r_idle;
      default: begin
        if (addr[4:3] == 2'b01) rd_data[W-1:0] = r_pat[addr[2:0]];
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/gpo_seq.md
# gpo_seq

Memory-mapped GPO pattern sequencer for the MMIO core slots. It plays up to eight programmable W-bit output patterns on `dout`, holding each pattern for a programmable number of clock cycles. Playback runs once or loops. When no sequence is running, `dout` shows a static idle value. Software configures and starts the block through the standard slot interface, so timed output waveforms need no CPU involvement per step.

## Interface
- `W`, default 8: width of `dout`, of each pattern entry and of the idle value.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `cs`  input  1: slot chip select.
- `read`  input  1: slot read strobe. Reads have no side effects.
- `write`  input  1: slot write strobe. A write is accepted on a rising edge where `cs && write`.
- `addr`  input  5: register address.
- `wr_data`  input  32: write data.
- `rd_data`  output  32: read data, combinational from `addr`.
- `dout`  output  W: sequenced output.

## Operation
- Register map: accesses to unmapped addresses are ignored on write and read back 0. Unused bits are ignored on write and read back 0.
  - addr 0, CTRL/STATUS.
    - Write: bit0 START, bit1 STOP, bit2 LOOP. LOOP is stored. START and STOP are self-clearing pulses.
    - Read: bit0 BUSY, bit1 DONE, bit2 LOOP, bits[6:4] current index.
  - addr 1, PERIOD[31:0]: cycles per step. A value of 0 behaves as 1.
  - addr 2, LAST[2:0]: index of the last entry played. Sequence length is LAST+1.
  - addr 3, IDLE[W-1:0]: value driven on `dout` when not busy.
  - addr 8..15, PAT[0..7][W-1:0]: pattern entries. They are writable at any time and read back the stored values.
- FSM has two states, IDLE and RUN.
  - IDLE, START written: go to RUN. Set idx=0 and cnt=0, and clear DONE.
  - RUN, each cycle: if cnt == max(PERIOD,1)-1, set cnt=0 and advance the step. Otherwise increment cnt.
  - Step advance when idx < LAST: increment idx.
  - Step advance when idx == LAST and LOOP=1: set idx=0.
  - Step advance when idx == LAST and LOOP=0: go to IDLE and set DONE=1.
  - RUN, START written: restart. Set idx=0 and cnt=0, clear DONE, stay in RUN.
  - Any state, STOP written: go to IDLE and clear cnt. DONE is not set.
  - START and STOP in the same write: STOP wins.
- `dout` = BUSY ? PAT[idx] : IDLE. The mux selects only registered values, so `dout` has no glitches from bus inputs.
- A write to PAT, PERIOD, LAST or LOOP while running takes effect immediately:
  - The new PAT[idx] appears on `dout` the cycle after the write.
  - A new PERIOD is compared against the current cnt.
  - If LAST is written below the current idx, the sequence runs to index 7, wraps past 7 to 0 (LOOP=1) or ends at 7 (LOOP=0), then honours LAST.
- DONE is sticky until the next START or reset.

## Timing
- Reset (`reset`=0, asynchronous) sets the following, all held while reset is asserted:
  - State IDLE; idx, cnt, PERIOD, LAST, LOOP, IDLE and all PAT entries 0; DONE 0.
  - `dout`=0.
  - `rd_data`=0 for every address.
- A reset assertion in the middle of a sequence aborts it immediately, with no completion.
- START is accepted at edge E:
  - BUSY=1 and `dout`=PAT[0] in the cycle after E.
  - Each entry is held for exactly max(PERIOD,1) cycles.
- Non-loop run: BUSY stays high for (LAST+1)*max(PERIOD,1) cycles. On the following edge, `dout` returns to IDLE and DONE=1 at the same time.
- STOP accepted at edge E: `dout`=IDLE in the cycle after E.
- `rd_data` is valid in the same cycle as `addr`, with no wait states. STATUS reflects the registered state.
- A write to IDLE while not busy is visible on `dout` the next cycle.

## Test plan
- Reset behaviour: assert `reset` low mid-run with PAT[0]=0xA5 and LOOP=1 → `dout`=0, BUSY=0 and all register reads 0 in the cycle of assertion and while reset is held.
- Single pass: PAT[0..2]=0x01,0x02,0x04, LAST=2, PERIOD=3, IDLE=0xFF, START → `dout` = 0x01 for 3 cycles, then 0x02 for 3, then 0x04 for 3, then 0xFF. DONE=1 and BUSY=0 when 0xFF first appears.
- Loop and PERIOD=0: PAT[0]=0x0F, PAT[1]=0xF0, LAST=1, PERIOD=0, LOOP=1, START → `dout` alternates 0x0F/0xF0 every cycle for 20 cycles. Reading STATUS shows BUSY=1, DONE=0.
- STOP and priority:
  - STOP mid-step during the loop run → `dout`=IDLE next cycle and DONE=0.
  - A write with START|STOP (0x3) while idle → stays idle.
- Restart and live edit:
  - START issued during step 2 of an 8-entry run → PAT[0] next cycle, full PERIOD honoured.
  - Writing PAT[idx]=0x3C during that step → 0x3C appears on `dout` next cycle.
- Full wrap: LAST=7, PERIOD=1, LOOP=0 with PAT[i]=1<<i → `dout` walks 0x01..0x80 over 8 consecutive cycles, then IDLE. A read at addr 20 returns 0.
